// File: rtl/dct_1d_seq_nx1_if.sv
// dct_1d_seq_nx1_if: vector-in / result-out handshake bundle for the sequential DCT stage.
interface dct_1d_seq_nx1_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         inverse;
    logic [DATA_WIDTH*N-1:0]      data_in;
    logic [DATA_WIDTH*N*N-1:0]    coeff_vector;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH*N-1:0]      dct_out;
    logic                         sat;
    modport master (
        output in_valid, data_in, inverse, coeff_vector, out_ready,
        input  in_ready, out_valid, dct_out, sat
    );
    modport slave (
        input  in_valid, data_in, inverse, coeff_vector, out_ready,
        output in_ready, out_valid, dct_out, sat
    );
endinterface

// File: rtl/dct_1d_seq_nx1.sv
// dct_1d_seq_nx1: time-multiplexed N-point 1-D DCT/IDCT, one input sample per cycle across N MAC lanes,
// then round, optional odd-lane negate and saturate into a registered output handshake.
module dct_1d_seq_nx1 #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8,
    parameter int FRAC_BITS  = 8,
    parameter int ODD_NEGATE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    dct_1d_seq_nx1_if.slave         bus
);
    localparam int JW = $clog2(N);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + JW;
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] RND  = FRAC_BITS > 0 ? (RW'(1) <<< (FRAC_BITS > 0 ? FRAC_BITS - 1 : 0)) : '0;
    localparam logic signed [RW-1:0] MAXV = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state_q;
    logic [JW-1:0]            j_q;
    logic [DATA_WIDTH*N-1:0]  x_q;
    logic                     inv_q;
    logic signed [AW-1:0]     acc_q [N];
    logic                     out_valid_q;
    logic [DATA_WIDTH*N-1:0]  dout_q;
    logic                     sat_q;

    logic signed [AW-1:0]     sum_d [N];
    logic [DATA_WIDTH*N-1:0]  dout_d;
    logic                     sat_d;
    logic                     release_out;
    logic                     accept;
    logic                     last;

    assign release_out  = state_q == DONE && bus.out_ready;
    assign bus.in_ready = state_q == IDLE || release_out;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last         = state_q == ACCUM && j_q == JW'(N - 1);
    assign bus.out_valid = out_valid_q;
    assign bus.dct_out   = dout_q;
    assign bus.sat       = sat_q;

    // sum_d already includes the current sample, so the result on the last step needs no extra cycle
    always_comb begin
        logic signed [DATA_WIDTH-1:0] xj;
        logic signed [DATA_WIDTH-1:0] c;
        logic signed [PW-1:0]         prod;
        logic signed [RW-1:0]         v;
        logic signed [RW-1:0]         r;
        xj     = x_q[j_q*DATA_WIDTH +: DATA_WIDTH];
        c      = '0;
        prod   = '0;
        v      = '0;
        r      = '0;
        dout_d = '0;
        sat_d  = 1'b0;
        for (int k = 0; k < N; k++) begin
            c        = inv_q ? bus.coeff_vector[(j_q*N + k)*DATA_WIDTH +: DATA_WIDTH]
                             : bus.coeff_vector[(k*N + j_q)*DATA_WIDTH +: DATA_WIDTH];
            prod     = xj * c;
            sum_d[k] = acc_q[k] + AW'(prod);
            v        = (ODD_NEGATE != 0 && k % 2 == 1) ? -RW'(sum_d[k]) : RW'(sum_d[k]);
            r        = (v + RND) >>> FRAC_BITS;
            dout_d[k*DATA_WIDTH +: DATA_WIDTH] = r > MAXV ? MAXV[DATA_WIDTH-1:0]
                                               : r < MINV ? MINV[DATA_WIDTH-1:0]
                                               : r[DATA_WIDTH-1:0];
            sat_d    = sat_d | (r > MAXV) | (r < MINV);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            j_q         <= '0;
            x_q         <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
            for (int k = 0; k < N; k++) acc_q[k] <= '0;
        end else begin
            if (accept) begin
                x_q   <= bus.data_in;
                inv_q <= bus.inverse;
                j_q   <= '0;
                for (int k = 0; k < N; k++) acc_q[k] <= '0;
            end else if (state_q == ACCUM) begin
                j_q <= j_q + 1'b1;
                for (int k = 0; k < N; k++) acc_q[k] <= sum_d[k];
            end
            if (last) begin
                dout_q <= dout_d;
                sat_q  <= sat_d;
            end
            out_valid_q <= last ? 1'b1 : release_out ? 1'b0 : out_valid_q;
            state_q     <= accept ? ACCUM : last ? DONE : release_out ? IDLE : state_q;
        end
    end
endmodule

// File: tb/tb_dct_1d_seq_nx1.sv
// tb_dct_1d_seq_nx1: table-driven, random and hand-sequenced checks of two DUT instances
// (odd-lane negation off and on) against a plain-arithmetic DCT model.
module tb_dct_1d_seq_nx1;
    localparam int W  = 16;
    localparam int NN = 8;
    localparam int F  = 8;
    localparam int VW = W * NN;
    localparam int CW = W * NN * NN;

    typedef struct {
        logic [VW-1:0] x;
        logic [CW-1:0] c;
        logic          inv;
        logic [VW-1:0] e0;
        logic          s0;
        logic [VW-1:0] e1;
        logic          s1;
    } vec_t;

    logic          clk = 0, reset = 0, in_valid = 0, inverse = 0, out_ready = 1;
    logic [VW-1:0] data_in = '0;
    logic [CW-1:0] coeff = '0;
    int            total = 0, bad = 0;
    vec_t          tbl[8];

    dct_1d_seq_nx1_if #(.DATA_WIDTH(W), .N(NN)) if0 ();
    dct_1d_seq_nx1_if #(.DATA_WIDTH(W), .N(NN)) if1 ();

    assign if0.in_valid = in_valid;
    assign if0.data_in = data_in;
    assign if0.inverse = inverse;
    assign if0.coeff_vector = coeff;
    assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;
    assign if1.data_in = data_in;
    assign if1.inverse = inverse;
    assign if1.coeff_vector = coeff;
    assign if1.out_ready = out_ready;

    dct_1d_seq_nx1 #(.DATA_WIDTH(W), .N(NN), .FRAC_BITS(F), .ODD_NEGATE(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    dct_1d_seq_nx1 #(.DATA_WIDTH(W), .N(NN), .FRAC_BITS(F), .ODD_NEGATE(1)) u1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [VW-1:0] pk(input int a[NN]);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) r[i*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    function automatic logic [VW-1:0] alt(input int ev, input int od);
        int a[NN];
        for (int i = 0; i < NN; i++) a[i] = (i % 2 == 0) ? ev : od;
        return pk(a);
    endfunction

    function automatic logic [CW-1:0] cset(input int k, input int j, input int v, input logic [CW-1:0] base);
        logic [CW-1:0] r;
        r = base;
        r[(k*NN + j)*W +: W] = v[W-1:0];
        return r;
    endfunction

    function automatic logic [CW-1:0] diag(input int v);
        logic [CW-1:0] r;
        r = '0;
        for (int k = 0; k < NN; k++) r = cset(k, k, v, r);
        return r;
    endfunction

    function automatic logic [CW-1:0] allc(input int v);
        logic [CW-1:0] r;
        r = '0;
        for (int k = 0; k < NN; k++)
            for (int j = 0; j < NN; j++) r = cset(k, j, v, r);
        return r;
    endfunction

    // Reference: y[k] = sum_j x[j]*C, negate, floor((v + half) / 2^F), clamp
    task automatic model(input logic [VW-1:0] x, input logic [CW-1:0] c, input logic inv, input bit oddn,
                         output logic [VW-1:0] res, output logic s);
        longint acc, xv, cv;
        res = '0;
        s = 1'b0;
        for (int k = 0; k < NN; k++) begin
            acc = 0;
            for (int j = 0; j < NN; j++) begin
                xv = $signed(x[j*W +: W]);
                cv = inv ? $signed(c[(j*NN + k)*W +: W]) : $signed(c[(k*NN + j)*W +: W]);
                acc += xv * cv;
            end
            if (oddn && k % 2 == 1) acc = -acc;
            acc = (acc + (longint'(1) << (F - 1))) >>> F;
            if (acc > 32767) begin acc = 32767; s = 1'b1; end
            else if (acc < -32768) begin acc = -32768; s = 1'b1; end
            res[k*W +: W] = acc[W-1:0];
        end
    endtask

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!if0.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_out(input string nm, input logic [VW-1:0] e0, input logic s0, input logic [VW-1:0] e1, input logic s1);
        chk({nm, "_valid1"}, VW'(if1.out_valid), VW'(1));
        chk({nm, "_out0"}, if0.dct_out, e0);
        chk({nm, "_sat0"}, VW'(if0.sat), VW'(s0));
        chk({nm, "_out1"}, if1.dct_out, e1);
        chk({nm, "_sat1"}, VW'(if1.sat), VW'(s1));
    endtask

    // One full job with out_ready high; latency counted in edges including the handshake edge
    task automatic run(input string nm, input logic [VW-1:0] x, input logic [CW-1:0] c, input logic inv,
                       input logic [VW-1:0] e0, input logic s0, input logic [VW-1:0] e1, input logic s1);
        int lat;
        chk({nm, "_in_ready"}, VW'(if0.in_ready), VW'(1));
        data_in = x;
        coeff = c;
        inverse = inv;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        wait_out(lat);
        chk({nm, "_latency"}, VW'(lat + 1), VW'(NN + 1));
        chk_out(nm, e0, s0, e1, s1);
        @(posedge clk);
        #1;
        chk({nm, "_drop"}, VW'(if0.out_valid), VW'(0));
    endtask

    initial begin
        int xa[NN];
        int lat;
        logic [VW-1:0] e0, e1, x1, x2, h0, h1;
        logic s0, s1;
        logic [CW-1:0] rc;

        #1 reset = 1;
        #1;
        chk("rst_in_ready", VW'(if0.in_ready), VW'(1));
        chk("rst_out_valid", VW'({if0.out_valid, if1.out_valid}), VW'(0));
        chk("rst_dct_out", if0.dct_out, '0);
        chk("rst_sat", VW'(if0.sat), VW'(0));
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        xa = '{1, -2, 3, -4, 100, -100, 32767, -32768};
        tbl[0] = '{pk(xa), diag(256), 1'b0, pk(xa), 1'b0, '0, 1'b1};
        xa = '{1, 2, 3, 4, 100, 100, 32767, 32767};
        tbl[0].e1 = pk(xa);
        tbl[1] = '{alt(5, 5), diag(256), 1'b0, alt(5, 5), 1'b0, alt(5, -5), 1'b0};
        tbl[2] = '{alt(1, 1), diag(384), 1'b0, alt(2, 2), 1'b0, alt(2, -1), 1'b0};
        tbl[3] = '{alt(32767, 32767), allc(256), 1'b0, alt(32767, 32767), 1'b1, alt(32767, -32768), 1'b1};
        tbl[4] = '{alt(-1, -1), diag(128), 1'b0, alt(0, 0), 1'b0, alt(0, 1), 1'b0};
        xa = '{0, 7, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{pk(xa), cset(0, 1, 256, '0), 1'b0, '0, 1'b0, '0, 1'b0};
        xa = '{7, 0, 0, 0, 0, 0, 0, 0};
        tbl[5].e0 = pk(xa);
        tbl[5].e1 = pk(xa);
        xa = '{0, 7, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{pk(xa), cset(0, 1, 256, '0), 1'b1, '0, 1'b0, '0, 1'b0};
        xa = '{7, 0, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{pk(xa), cset(0, 1, 256, '0), 1'b1, '0, 1'b0, '0, 1'b0};
        xa = '{0, 7, 0, 0, 0, 0, 0, 0};
        tbl[7].e0 = pk(xa);
        xa = '{0, -7, 0, 0, 0, 0, 0, 0};
        tbl[7].e1 = pk(xa);

        for (int i = 0; i < 8; i++)
            run($sformatf("tbl%0d", i), tbl[i].x, tbl[i].c, tbl[i].inv, tbl[i].e0, tbl[i].s0, tbl[i].e1, tbl[i].s1);

        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < NN; j++) x1[j*W +: W] = W'($urandom_range(0, 65535));
            for (int j = 0; j < NN * NN; j++) begin
                int v;
                v = (i % 2 == 0) ? int'($urandom_range(0, 1023)) - 512 : int'($urandom_range(0, 65535)) - 32768;
                rc[j*W +: W] = v[W-1:0];
            end
            model(x1, rc, i % 3 == 0, 0, e0, s0);
            model(x1, rc, i % 3 == 0, 1, e1, s1);
            run($sformatf("rnd%0d", i), x1, rc, i % 3 == 0, e0, s0, e1, s1);
        end

        // back-pressure, ignored misuse, then simultaneous output and input handshake
        xa = '{9, -8, 7, -6, 5, -4, 3, -2};
        x1 = pk(xa);
        x2 = alt(1000, -1000);
        out_ready = 0;
        data_in = x1;
        coeff = diag(300);
        inverse = 0;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        wait_out(lat);
        chk("bp_latency", VW'(lat + 1), VW'(NN + 1));
        model(x1, diag(300), 0, 0, e0, s0);
        model(x1, diag(300), 0, 1, e1, s1);
        chk_out("bp_first", e0, s0, e1, s1);
        h0 = if0.dct_out;
        h1 = if1.dct_out;
        data_in = alt(-7, 7);
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_in_ready", i), VW'(if0.in_ready), VW'(0));
            chk($sformatf("bp_hold%0d_valid", i), VW'(if0.out_valid), VW'(1));
            chk($sformatf("bp_hold%0d_out0", i), if0.dct_out, h0);
            chk($sformatf("bp_hold%0d_out1", i), if1.dct_out, h1);
        end
        data_in = x2;
        out_ready = 1;
        #1;
        chk("b2b_in_ready", VW'(if0.in_ready), VW'(1));
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("b2b_drop", VW'(if0.out_valid), VW'(0));
        wait_out(lat);
        chk("b2b_latency", VW'(lat + 1), VW'(NN + 1));
        model(x2, diag(300), 0, 0, e0, s0);
        model(x2, diag(300), 0, 1, e1, s1);
        chk_out("b2b_second", e0, s0, e1, s1);
        @(posedge clk);
        #1;

        // abort a job at j=4 with asynchronous reset
        xa = '{11, -22, 33, -44, 55, -66, 77, -88};
        x1 = pk(xa);
        data_in = x1;
        coeff = diag(256);
        inverse = 0;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1;
        #1;
        chk("mid_rst_valid", VW'({if0.out_valid, if1.out_valid}), VW'(0));
        chk("mid_rst_out", if0.dct_out, '0);
        chk("mid_rst_in_ready", VW'(if0.in_ready), VW'(1));
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        xa = '{11, 22, 33, 44, 55, 66, 77, 88};
        run("post_rst", x1, diag(256), 0, x1, 0, pk(xa), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
